mem_port_arbiter: RTL and testbench

//  Shares one single-ported 1024x16 memory between instruction fetch (IF) and the data-memory stage (DM).

---
 rtl/mips16_pkg.sv | 16 +
 rtl/arb_starve_ctr.sv | 26 ++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips16_pkg.sv
// Shared types and constants for the MIPS16 memory-port arbiter.
package mips16_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

  localparam int MEM_AW_DEF = 10;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive data-port wins over a waiting fetch; at_max forces the next fetch grant.
module arb_starve_ctr #(
  parameter int MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [3:0] cnt;

  assign at_max = (cnt == 4'(MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (IF) and data (DM) requesters.
// Optional feature macro: ARB_STALL_CNT_EN adds the if_stall_cnt output.
module mem_port_arbiter
  import mips16_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int MEM_AW     = MEM_AW_DEF,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef ARB_STALL_CNT_EN
  ,
  output logic [15:0]       if_stall_cnt
`endif
);

  arb_state_t  state;
  logic        owner;
  logic [2:0]  lat_cnt;
  logic        at_max;
  logic        grant_dm;
  logic        grant_if;
  logic        starve_inc;
  logic        starve_clr;
  logic [ADDR_W-1:0] sel_addr;
  logic        addr_unused;

  // Data wins unless the fetch has already been passed over STARVE_MAX times.
  assign grant_dm   = dm_req && (!if_req || !at_max);
  assign grant_if   = if_req && !grant_dm;
  assign starve_inc = (state == IDLE) && if_req && dm_req && !at_max;
  assign starve_clr = (state == IDLE) && grant_if;
  assign sel_addr   = grant_dm ? dm_addr : if_addr;

  // Byte-offset bit and bits above the word range are discarded by design.
  assign addr_unused = ^{sel_addr[0], sel_addr[ADDR_W-1:MEM_AW+1]};

  arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .at_max (at_max)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWNER_IF;
      lat_cnt   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            owner     <= grant_dm ? OWNER_DM : OWNER_IF;
            mem_addr  <= sel_addr[MEM_AW:1];
            mem_we    <= grant_dm && dm_we;
            mem_wdata <= grant_dm ? dm_wdata : '0;
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (MEM_LAT == 1) begin
            if_ack <= (owner == OWNER_IF);
            dm_ack <= (owner == OWNER_DM);
            state  <= DONE;
          end else begin
            lat_cnt <= 3'(MEM_LAT - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == 3'd1) begin
            if_ack <= (owner == OWNER_IF);
            dm_ack <= (owner == OWNER_DM);
            state  <= DONE;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data comes straight from the array during DONE; stores return zero.
  assign if_rdata = if_ack ? mem_rdata : '0;
  assign dm_rdata = (dm_ack && !mem_we) ? mem_rdata : '0;

`ifdef ARB_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      if_stall_cnt <= '0;
    end else if (if_req && !if_ack && (if_stall_cnt != 16'hFFFF)) begin
      if_stall_cnt <= if_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        port;
    logic [15:0] data;
  } ack_t;

  typedef struct packed {
    logic        we;
    logic [9:0]  addr;
    logic [15:0] wdata;
  } macc_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  ack_t  ack_q1[$];
  ack_t  ack_q3[$];
  macc_t mem_q1[$];
  macc_t mem_q3[$];

  // instance 1 (MEM_LAT=1)
  logic        rst1, if_req1, if_ack1, dm_req1, dm_we1, dm_ack1, mem_en1, mem_we1, busy1;
  logic [15:0] if_addr1, if_rdata1, dm_addr1, dm_wdata1, dm_rdata1, mem_wdata1, mem_rdata1;
  logic [9:0]  mem_addr1;
  // instance 3 (MEM_LAT=3)
  logic        rst3, if_req3, if_ack3, dm_req3, dm_we3, dm_ack3, mem_en3, mem_we3, busy3;
  logic [15:0] if_addr3, if_rdata3, dm_addr3, dm_wdata3, dm_rdata3, mem_wdata3, mem_rdata3;
  logic [9:0]  mem_addr3;
`ifdef ARB_STALL_CNT_EN
  logic [15:0] stall1, stall3;
`endif

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(3)) u_dut1 (
    .clk(clk), .rst(rst1),
    .if_req(if_req1), .if_addr(if_addr1), .if_ack(if_ack1), .if_rdata(if_rdata1),
    .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
    .dm_ack(dm_ack1), .dm_rdata(dm_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1)
`ifdef ARB_STALL_CNT_EN
    , .if_stall_cnt(stall1)
`endif
  );

  mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(3)) u_dut3 (
    .clk(clk), .rst(rst3),
    .if_req(if_req3), .if_addr(if_addr3), .if_ack(if_ack3), .if_rdata(if_rdata3),
    .dm_req(dm_req3), .dm_we(dm_we3), .dm_addr(dm_addr3), .dm_wdata(dm_wdata3),
    .dm_ack(dm_ack3), .dm_rdata(dm_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3)
`ifdef ARB_STALL_CNT_EN
    , .if_stall_cnt(stall3)
`endif
  );

  // memory models: word i preloaded with A000+i (inst 1) and B000+i (inst 3)
  logic [15:0] mem1 [0:1023];
  logic [15:0] mem3 [0:1023];
  logic [15:0] rd1_q;
  logic [15:0] p3a, p3b, p3c;

  always @(posedge clk) begin
    if (mem_en1) begin
      rd1_q <= mem1[mem_addr1];
      if (mem_we1) mem1[mem_addr1] <= mem_wdata1;
    end
  end
  assign mem_rdata1 = rd1_q;

  always @(posedge clk) begin
    p3a <= mem3[mem_addr3];
    p3b <= p3a;
    p3c <= p3b;
    if (mem_en3 && mem_we3) mem3[mem_addr3] <= mem_wdata3;
  end
  assign mem_rdata3 = p3c;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // monitors: pop expectations whenever a DUT presents an ack or a memory strobe
  always @(negedge clk) begin
    ack_t  ea;
    macc_t em;
    if (if_ack1 || dm_ack1) begin
      if (if_ack1 && dm_ack1) begin
        checkOutput("ack_exclusive_d1", {if_ack1, dm_ack1}, 32'h1);
      end else if (ack_q1.size() == 0) begin
        checkOutput("unexpected_ack_d1", {if_ack1, dm_ack1}, 32'h0);
      end else begin
        ea = ack_q1.pop_front();
        checkOutput("ack_d1", {dm_ack1, (dm_ack1 ? dm_rdata1 : if_rdata1)}, {ea.port, ea.data});
      end
    end
    if (mem_en1) begin
      if (mem_q1.size() == 0) begin
        checkOutput("unexpected_mem_en_d1", {mem_we1, mem_addr1}, 32'h0);
      end else begin
        em = mem_q1.pop_front();
        checkOutput("mem_access_d1", {mem_we1, mem_addr1, mem_wdata1}, {em.we, em.addr, em.wdata});
      end
    end
  end

  always @(negedge clk) begin
    ack_t  ea;
    macc_t em;
    if (if_ack3 || dm_ack3) begin
      if (ack_q3.size() == 0) begin
        checkOutput("unexpected_ack_d3", {if_ack3, dm_ack3}, 32'h0);
      end else begin
        ea = ack_q3.pop_front();
        checkOutput("ack_d3", {dm_ack3, (dm_ack3 ? dm_rdata3 : if_rdata3)}, {ea.port, ea.data});
      end
    end
    if (mem_en3) begin
      if (mem_q3.size() == 0) begin
        checkOutput("unexpected_mem_en_d3", {mem_we3, mem_addr3}, 32'h0);
      end else begin
        em = mem_q3.pop_front();
        checkOutput("mem_access_d3", {mem_we3, mem_addr3, mem_wdata3}, {em.we, em.addr, em.wdata});
      end
    end
  end

  // single transaction on instance 1; called at posedge+1 of an IDLE cycle
  task automatic applyStimulus(input logic is_dm, input logic we, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic [15:0] exp_data,
                               input logic [9:0] exp_maddr);
    ack_t  ea;
    macc_t em;
    int    k;
    int    en_k;
    logic  got;
    ea.port = is_dm; ea.data = exp_data;
    em.we = is_dm & we; em.addr = exp_maddr; em.wdata = is_dm ? wdata : 16'h0;
    ack_q1.push_back(ea);
    mem_q1.push_back(em);
    if (is_dm) begin
      dm_req1 = 1'b1; dm_we1 = we; dm_addr1 = addr; dm_wdata1 = wdata;
    end else begin
      if_req1 = 1'b1; if_addr1 = addr;
    end
    k = 0; en_k = 0; got = 1'b0;
    while (!got && k < 20) begin
      @(posedge clk); #1;
      k++;
      if (mem_en1 && en_k == 0) en_k = k;
      if (if_ack1 || dm_ack1) got = 1'b1;
    end
    if_req1 = 1'b0; dm_req1 = 1'b0;
    checkOutput("mem_en_cycle", en_k, 1);
    checkOutput("ack_cycle", k, 2);
    @(posedge clk); #1;
    checkOutput("idle_after_txn", busy1, 0);
  endtask

  // DM load on instance 3, optionally pulsing rst in cycle abort_at
  task automatic applyStimulus3(input logic [15:0] addr, input logic [15:0] exp_data,
                                input logic [9:0] exp_maddr, input int abort_at);
    ack_t  ea;
    macc_t em;
    int    ack_k;
    int    busy_n;
    ea.port = 1'b1; ea.data = exp_data;
    em.we = 1'b0; em.addr = exp_maddr; em.wdata = 16'h0;
    if (abort_at == 0) ack_q3.push_back(ea);
    mem_q3.push_back(em);
    dm_req3 = 1'b1; dm_we3 = 1'b0; dm_addr3 = addr; dm_wdata3 = 16'h0;
    ack_k = 0; busy_n = 0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (busy3) busy_n++;
      if (dm_ack3 && ack_k == 0) ack_k = k;
      if (dm_ack3) dm_req3 = 1'b0;
      if (abort_at != 0 && k == abort_at) begin
        rst3 = 1'b1; dm_req3 = 1'b0;
      end else begin
        rst3 = 1'b0;
      end
    end
    if (abort_at == 0) begin
      checkOutput("lat3_ack_cycle", ack_k, 4);
      checkOutput("lat3_busy_cycles", busy_n, 4);
    end else begin
      checkOutput("abort_no_ack", ack_k, 0);
      checkOutput("abort_busy_cycles", busy_n, abort_at);
    end
    checkOutput("lat3_idle", busy3, 0);
  endtask

  task automatic contention();
    ack_t  ed, ei;
    macc_t md, mi;
    int    n;
    int    cyc;
    ed.port = 1'b1; ed.data = 16'hA010;
    ei.port = 1'b0; ei.data = 16'hA020;
    md.we = 1'b0; md.addr = 10'd16; md.wdata = 16'h0;
    mi.we = 1'b0; mi.addr = 10'd32; mi.wdata = 16'h0;
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 3; j++) begin
        ack_q1.push_back(ed);
        mem_q1.push_back(md);
      end
      ack_q1.push_back(ei);
      mem_q1.push_back(mi);
    end
    if_req1 = 1'b1; if_addr1 = 16'h0040;
    dm_req1 = 1'b1; dm_we1 = 1'b0; dm_addr1 = 16'h0020; dm_wdata1 = 16'h0;
    n = 0; cyc = 0;
    while (n < 8 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (if_ack1 || dm_ack1) n++;
    end
    if_req1 = 1'b0; dm_req1 = 1'b0;
    checkOutput("contention_acks", n, 8);
    checkOutput("contention_cycles", cyc, 23);
    @(posedge clk); #1;
    checkOutput("contention_idle", busy1, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem1[i] = 16'hA000 + 16'(i);
      mem3[i] = 16'hB000 + 16'(i);
    end
    rst1 = 1'b1; rst3 = 1'b1;
    if_req1 = 1'b1; dm_req1 = 1'b1; dm_we1 = 1'b0;
    if_addr1 = 16'h0; dm_addr1 = 16'h0; dm_wdata1 = 16'h0;
    if_req3 = 1'b0; dm_req3 = 1'b0; dm_we3 = 1'b0;
    if_addr3 = 16'h0; dm_addr3 = 16'h0; dm_wdata3 = 16'h0;

    $display("[TB] reset with both requests held");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checkOutput("reset_outputs", {mem_en1, if_ack1, dm_ack1, busy1}, 0);
    end
    if_req1 = 1'b0; dm_req1 = 1'b0;
    rst1 = 1'b0; rst3 = 1'b0;
    @(posedge clk); #1;

    $display("[TB] single fetches and data accesses");
    applyStimulus(1'b0, 1'b0, 16'h0006, 16'h0000, 16'hA003, 10'd3);
    applyStimulus(1'b1, 1'b1, 16'h0010, 16'h00AB, 16'h0000, 10'd8);
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 16'h00AB, 10'd8);
    applyStimulus(1'b1, 1'b0, 16'h0011, 16'h0000, 16'h00AB, 10'd8);
    applyStimulus(1'b0, 1'b0, 16'h07FF, 16'h0000, 16'hA3FF, 10'd1023);
    applyStimulus(1'b0, 1'b0, 16'hF806, 16'h0000, 16'hA003, 10'd3);

    $display("[TB] contention with both requests held");
    contention();

    $display("[TB] MEM_LAT=3 load and reset during WAIT");
    applyStimulus3(16'h0014, 16'hB00A, 10'd10, 0);
    applyStimulus3(16'h0018, 16'h0000, 10'd12, 2);
    applyStimulus3(16'h0016, 16'hB00B, 10'd11, 0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", ack_q1.size() + ack_q3.size() + mem_q1.size() + mem_q3.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
